// File: rtl/pdp8_trace_buffer_pkg.sv
// Shared types for the PDP-8 trace recorder: record kinds, capture states, record layout.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pdp8_trace_buffer_pkg;

    typedef enum logic [2:0] {
        TK_IF            = 3'd0,
        TK_DR            = 3'd1,
        TK_DW            = 3'd2,
        TK_BR_SUB        = 3'd3,
        TK_BR_UNC        = 3'd4,
        TK_BR_COND_TAKEN = 3'd5,
        TK_BR_COND_NOT   = 3'd6,
        TK_MEM_ERR       = 3'd7
    } trace_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } cap_state_t;

    // Record layout at the native PDP-8 word width; the top is parametrised and
    // packs the same {kind, f0, f1, f2} order for any DATA_W.
    localparam int TRACE_DATA_W = 12;

    typedef struct packed {
        trace_kind_t             kind;
        logic [TRACE_DATA_W-1:0] f0;
        logic [TRACE_DATA_W-1:0] f1;
        logic [TRACE_DATA_W-1:0] f2;
    } trace_record_t;

    // br_kind: 0 subroutine, 1 unconditional, 2 (and 3) conditional.
    function automatic trace_kind_t br_kind_map(input logic [1:0] kind, input logic taken);
        trace_kind_t k;
        if (kind == 2'd0)      k = TK_BR_SUB;
        else if (kind == 2'd1) k = TK_BR_UNC;
        else if (taken)        k = TK_BR_COND_TAKEN;
        else                   k = TK_BR_COND_NOT;
        return k;
    endfunction

endpackage

// File: rtl/pdp8_trace_buffer_fifo.sv
// Circular record buffer, first-word-fall-through, optional overwrite-oldest when full.
// Latency: push to rd_dat_o/!empty_o visible 1 cycle later.
// Backpressure: none on push; a push into a full buffer without a same-cycle pop raises drop_o.
// Ports: clk_i/reset_i/clear_i control; push_i/push_dat_i write side; pop_i read side;
//        rd_dat_o head record; count_o/full_o/empty_o occupancy; drop_o one-cycle loss strobe.
module pdp8_trace_buffer_fifo #(
    parameter int DEPTH     = 256,
    parameter int W         = 39,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rd_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic pop_ok, overflow, do_write, rd_adv, grow;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    // A same-cycle pop frees the slot, so only an unpopped push into full overflows.
    assign pop_ok   = pop_i && !empty_o;
    assign overflow = push_i && full_o && !pop_ok;
    assign do_write = push_i && (!overflow || (WRAP_MODE != 0));
    // Overwrite mode retires the oldest entry to make room for the new one.
    assign rd_adv   = pop_ok || (overflow && (WRAP_MODE != 0));
    assign grow     = do_write && !overflow;
    assign drop_o   = overflow;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_adv)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (grow && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!grow && pop_ok) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write && !reset_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/pdp8_trace_buffer.sv
// PDP-8 execution trace recorder: formats memory/branch events into records for a circular buffer.
// Latency: event to rec_valid 1 cycle when empty; a branch coincident with a mem event lands 1 cycle later.
// Backpressure: rec_valid/rec_ready drain; producer side never stalls, losses are counted in dropped.
// Ports: clk/reset; capture_en/run/clear control capture; mem_* and br_* are the CPU event taps;
//        rec_valid/rec_ready/rec_data drain port; count/full/empty/dropped/state status.
module pdp8_trace_buffer
    import pdp8_trace_buffer_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int DATA_W    = 12,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 16,
    parameter int REC_W     = 3 + 3*DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     run,
    input  logic                     clear,
    input  logic                     mem_finished,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic                     read_type,
    input  logic [DATA_W-1:0]        address,
    input  logic [DATA_W-1:0]        bus_data,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     br_valid,
    input  logic [1:0]               br_kind,
    input  logic                     br_taken,
    input  logic [DATA_W-1:0]        br_pc,
    input  logic [DATA_W-1:0]        br_target,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [REC_W-1:0]         rec_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         dropped,
    output logic [1:0]               state
);
    cap_state_t         state_q;
    logic               run_q;
    logic               freeze_q;
    logic               pend_vld_q, pend_vld_d;
    logic [REC_W-1:0]   pend_dat_q, pend_dat_d;
    logic [CNT_W-1:0]   drop_q;

    trace_kind_t        mem_kind;
    logic [REC_W-1:0]   mem_rec, br_rec, push_dat;
    logic               push, br_drop, fifo_drop, capturing;
    logic [1:0]         drop_inc;
    logic [CNT_W:0]     drop_sum;

    always_comb begin
        if (read_enable)       mem_kind = read_type ? TK_DR : TK_IF;
        else if (write_enable) mem_kind = TK_DW;
        else                   mem_kind = TK_MEM_ERR;
    end

    assign mem_rec   = {mem_kind, address, bus_data, mem_data};
    assign br_rec    = {br_kind_map(br_kind, br_taken), br_pc, br_target, {DATA_W{1'b0}}};
    assign capturing = (state_q == ST_CAPTURE);

    // Single write port: mem events win; a coincident branch parks in the pending
    // register and is written on the next cycle without a mem event.
    always_comb begin
        push       = 1'b0;
        push_dat   = mem_rec;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        br_drop    = 1'b0;
        if (capturing) begin
            if (mem_finished) begin
                push = 1'b1;
                if (br_valid) begin
                    if (pend_vld_q) begin
                        br_drop = 1'b1;
                    end else begin
                        pend_vld_d = 1'b1;
                        pend_dat_d = br_rec;
                    end
                end
            end else if (pend_vld_q) begin
                push       = 1'b1;
                push_dat   = pend_dat_q;
                pend_vld_d = br_valid;
                if (br_valid) pend_dat_d = br_rec;
            end else if (br_valid) begin
                push     = 1'b1;
                push_dat = br_rec;
            end
        end
    end

    pdp8_trace_buffer_fifo #(
        .DEPTH     (DEPTH),
        .W         (REC_W),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (clear),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (rec_ready),
        .rd_dat_o   (rec_data),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .drop_o     (fifo_drop)
    );

    // A branch drop and a buffer overflow can coincide, so the counter may step by 2.
    assign drop_inc = {1'b0, fifo_drop} + {1'b0, br_drop};
    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);

    always_ff @(posedge clk) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= run;

        if (reset || clear) begin
            state_q    <= ST_IDLE;
            freeze_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            drop_q     <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            drop_q     <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            case (state_q)
                ST_IDLE: begin
                    if (capture_en && run && !run_q) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Run has stopped: freeze once the pending branch has been flushed.
                    if ((run_q && !run) || freeze_q) begin
                        if (!pend_vld_d) begin
                            state_q  <= ST_FROZEN;
                            freeze_q <= 1'b0;
                        end else begin
                            freeze_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_FROZEN;
            endcase
        end
    end

    assign rec_valid = !empty;
    assign dropped   = drop_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
`timescale 1ns/1ps
module tb_pdp8_trace_buffer;
    import pdp8_trace_buffer_pkg::*;

    localparam int DW = 12;
    localparam int RW = 3 + 3*DW;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, capture_en = 1'b0, run = 1'b0, clear = 1'b0;
    logic          mem_finished = 1'b0, read_enable = 1'b0, write_enable = 1'b0, read_type = 1'b0;
    logic [DW-1:0] address = '0, bus_data = '0, mem_data = '0;
    logic          br_valid = 1'b0, br_taken = 1'b0;
    logic [1:0]    br_kind = '0;
    logic [DW-1:0] br_pc = '0, br_target = '0;
    logic          rec_ready = 1'b0;

    logic          rv   [2];
    logic [RW-1:0] rd   [2];
    logic [2:0]    cnt  [2];
    logic          fl   [2];
    logic          em   [2];
    logic [1:0]    st   [2];
    logic [15:0]   dr0;
    logic [2:0]    dr1;

    pdp8_trace_buffer #(.DEPTH(D), .DATA_W(DW), .WRAP_MODE(0), .CNT_W(16)) u_stop (
        .clk(clk), .reset(reset), .capture_en(capture_en), .run(run), .clear(clear),
        .mem_finished(mem_finished), .read_enable(read_enable), .write_enable(write_enable),
        .read_type(read_type), .address(address), .bus_data(bus_data), .mem_data(mem_data),
        .br_valid(br_valid), .br_kind(br_kind), .br_taken(br_taken), .br_pc(br_pc),
        .br_target(br_target), .rec_valid(rv[0]), .rec_ready(rec_ready), .rec_data(rd[0]),
        .count(cnt[0]), .full(fl[0]), .empty(em[0]), .dropped(dr0), .state(st[0]));

    pdp8_trace_buffer #(.DEPTH(D), .DATA_W(DW), .WRAP_MODE(1), .CNT_W(3)) u_wrap (
        .clk(clk), .reset(reset), .capture_en(capture_en), .run(run), .clear(clear),
        .mem_finished(mem_finished), .read_enable(read_enable), .write_enable(write_enable),
        .read_type(read_type), .address(address), .bus_data(bus_data), .mem_data(mem_data),
        .br_valid(br_valid), .br_kind(br_kind), .br_taken(br_taken), .br_pc(br_pc),
        .br_target(br_target), .rec_valid(rv[1]), .rec_ready(rec_ready), .rec_data(rd[1]),
        .count(cnt[1]), .full(fl[1]), .empty(em[1]), .dropped(dr1), .state(st[1]));

    // Reference model: each recorder is a bounded queue of records plus a run/freeze mode.
    logic [RW-1:0] mq [2][$];
    int            m_mode [2];      // 0 idle, 1 capturing, 2 frozen
    bit            m_hold [2];      // branch waiting for a free write slot
    logic [RW-1:0] m_hrec [2];
    bit            m_stop [2];      // run has stopped, waiting to flush the held branch
    int            m_drop [2];
    int            drop_max [2] = '{65535, 7};
    bit            m_run_prev;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [RW-1:0] mk(trace_kind_t k, logic [DW-1:0] a, logic [DW-1:0] b,
                                         logic [DW-1:0] c);
        trace_record_t r;
        r.kind = k; r.f0 = a; r.f1 = b; r.f2 = c;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] exp_mem_rec();
        trace_kind_t k;
        if (read_enable)       k = read_type ? TK_DR : TK_IF;
        else if (write_enable) k = TK_DW;
        else                   k = TK_MEM_ERR;
        return mk(k, address, bus_data, mem_data);
    endfunction

    function automatic logic [RW-1:0] exp_br_rec();
        trace_kind_t k;
        case (br_kind)
            2'd0:    k = TK_BR_SUB;
            2'd1:    k = TK_BR_UNC;
            default: k = br_taken ? TK_BR_COND_TAKEN : TK_BR_COND_NOT;
        endcase
        return mk(k, br_pc, br_target, '0);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset || clear) begin
                mq[i].delete();
                m_mode[i] = 0; m_hold[i] = 0; m_stop[i] = 0; m_drop[i] = 0;
            end else begin
                int losses = 0;
                bit have = 0;
                logic [RW-1:0] w = '0;
                if (rec_ready && mq[i].size() > 0) void'(mq[i].pop_front());
                if (m_mode[i] == 1) begin
                    if (mem_finished) begin
                        have = 1; w = exp_mem_rec();
                        if (br_valid) begin
                            if (m_hold[i]) losses++;
                            else begin m_hold[i] = 1; m_hrec[i] = exp_br_rec(); end
                        end
                    end else if (m_hold[i]) begin
                        have = 1; w = m_hrec[i];
                        m_hold[i] = br_valid;
                        if (br_valid) m_hrec[i] = exp_br_rec();
                    end else if (br_valid) begin
                        have = 1; w = exp_br_rec();
                    end
                    if (have) begin
                        if (mq[i].size() == D) begin
                            losses++;
                            if (i == 1) begin
                                void'(mq[i].pop_front());
                                mq[i].push_back(w);
                            end
                        end else begin
                            mq[i].push_back(w);
                        end
                    end
                    if (m_run_prev && !run) m_stop[i] = 1;
                    if (m_stop[i] && !m_hold[i]) begin m_mode[i] = 2; m_stop[i] = 0; end
                end else if (m_mode[i] == 0) begin
                    if (capture_en && run && !m_run_prev) m_mode[i] = 1;
                end
                m_drop[i] = (m_drop[i] + losses > drop_max[i]) ? drop_max[i] : m_drop[i] + losses;
            end
        end
        m_run_prev = reset ? 1'b0 : run;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count%0d", i), cnt[i], mq[i].size());
            chk($sformatf("full%0d", i), fl[i], mq[i].size() == D);
            chk($sformatf("empty%0d", i), em[i], mq[i].size() == 0);
            chk($sformatf("valid%0d", i), rv[i], mq[i].size() != 0);
            chk($sformatf("state%0d", i), st[i], m_mode[i]);
            chk($sformatf("dropped%0d", i), (i == 0) ? 64'(dr0) : 64'(dr1), m_drop[i]);
            if (mq[i].size() != 0) chk($sformatf("data%0d", i), rd[i], mq[i][0]);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        mem_finished = 1'b0;
        br_valid     = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic mem_ev(input logic re, input logic we, input logic rt, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] m);
        mem_finished = 1'b1; read_enable = re; write_enable = we; read_type = rt;
        address = a; bus_data = b; mem_data = m;
    endtask

    task automatic br_ev(input logic [1:0] k, input logic tk, input logic [DW-1:0] pc,
                         input logic [DW-1:0] tgt);
        br_valid = 1'b1; br_kind = k; br_taken = tk; br_pc = pc; br_target = tgt;
    endtask

    // Flush, then present a run rising edge with capture armed.
    task automatic arm();
        rec_ready = 1'b0; clear = 1'b1; run = 1'b0; capture_en = 1'b1;
        cyc();
        run = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        cyc(); cyc();
        chk("rst_count", cnt[0], 0);
        chk("rst_empty", em[0], 1);
        chk("rst_valid", rv[1], 0);
        chk("rst_state", st[0], ST_IDLE);
        reset = 1'b0;

        // First capture: IF 0200
        capture_en = 1'b1; run = 1'b1;
        cyc();
        chk("arm_state", st[0], ST_CAPTURE);
        mem_ev(1, 0, 0, 12'o0200, 12'o7200, 12'o7200);
        cyc();
        chk("if_data", rd[0], mk(TK_IF, 12'o0200, 12'o7200, 12'o7200));
        chk("if_count", cnt[0], 1);
        rec_ready = 1'b1; cyc(); rec_ready = 1'b0;

        // Six writes into a 4-deep buffer
        for (int k = 1; k <= 6; k++) begin
            mem_ev(0, 1, 0, 12'(k), 12'(k + 100), 12'(k + 200));
            cyc();
        end
        chk("stop_full", fl[0], 1);
        chk("stop_count", cnt[0], 4);
        chk("stop_dropped", dr0, 2);
        chk("stop_first", rd[0], mk(TK_DW, 12'd1, 12'd101, 12'd201));
        chk("wrap_count", cnt[1], 4);
        chk("wrap_dropped", dr1, 2);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_order", rd[1], mk(TK_DW, 12'(3 + k), 12'(103 + k), 12'(203 + k)));
            rec_ready = 1'b1;
            cyc();
        end
        rec_ready = 1'b0;

        // Coincident DR and JMP
        arm();
        mem_ev(1, 0, 1, 12'o0300, 12'o1234, 12'o1234);
        br_ev(2'd1, 1'b0, 12'o0201, 12'o0250);
        cyc();
        cyc();
        chk("pair_count", cnt[0], 2);
        chk("pair_dr", rd[0], mk(TK_DR, 12'o0300, 12'o1234, 12'o1234));
        rec_ready = 1'b1; cyc(); rec_ready = 1'b0;
        chk("pair_br", rd[0], mk(TK_BR_UNC, 12'o0201, 12'o0250, 12'o0000));

        // Full buffer, push and pop together; then hold
        arm();
        for (int k = 1; k <= 4; k++) begin
            mem_ev(1, 0, 0, 12'(k), 12'(k), 12'(k));
            cyc();
        end
        mem_ev(1, 0, 0, 12'd5, 12'd5, 12'd5);
        rec_ready = 1'b1;
        cyc();
        rec_ready = 1'b0;
        chk("pp_count", cnt[0], 4);
        chk("pp_dropped", dr0, 0);
        cyc(); cyc();
        chk("hold_data", rd[0], mk(TK_IF, 12'd2, 12'd2, 12'd2));

        // Pending branch at run fall, then freeze and clear
        arm();
        mem_ev(0, 1, 0, 12'o0400, 12'o0001, 12'o0001); br_ev(2'd0, 1'b0, 12'o0401, 12'o0500);
        cyc();
        mem_ev(0, 1, 0, 12'o0402, 12'o0002, 12'o0002); br_ev(2'd2, 1'b1, 12'o0403, 12'o0600);
        cyc();
        run = 1'b0;
        cyc();
        chk("frz_state", st[0], ST_FROZEN);
        chk("frz_count", cnt[0], 3);
        chk("frz_dropped", dr0, 1);
        mem_ev(1, 0, 0, 12'o0777, 12'o0, 12'o0);
        cyc();
        chk("frz_ignore", cnt[0], 3);
        clear = 1'b1;
        cyc();
        chk("clr_state", st[0], ST_IDLE);
        chk("clr_count", cnt[1], 0);

        // Randomised traffic
        run = 1'b0; capture_en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            clear = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 49) == 0) capture_en = ~capture_en;
            rec_ready = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 1) == 1)
                mem_ev(1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom),
                       12'($urandom), 12'($urandom));
            if ($urandom_range(0, 9) < 4)
                br_ev(2'($urandom_range(0, 2)), 1'($urandom), 12'($urandom), 12'($urandom));
            cyc();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
